// File: rtl/uart_msg_tx.sv
// UART message sender: serialises the first msg_len buffer bytes as 8N1 frames (8E1 parity bit when UART_MSG_PARITY_EN is defined), once or repeating.
// Latency: start sampled at edge N, start bit on the line from edge N+1; frames are back-to-back, done pulses the cycle after the last stop bit.
// Backpressure: none; start is ignored while a message is pending or in progress.
module uart_msg_tx #(
    parameter int BAUD_DIV = 5208,
    parameter int DEPTH    = 32,
    parameter int AW       = 5
) (
    input  logic          RST_clk,
    input  logic          RST_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW:0]   msg_len,
    input  logic          start,
    input  logic          repeat_en,
    output logic          uart_tx_data,
    output logic          uart_busy,
    output logic          done,
    output logic [AW-1:0] cur_idx
);

    localparam int            CW      = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(BAUD_DIV - 1);
    localparam logic [AW:0]   DEPTH_L = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [7:0] mem_q [DEPTH];

    state_t        state_q,  state_d;
    logic [CW-1:0] cnt_q,    cnt_d;
    logic [2:0]    bit_q,    bit_d;
    logic [7:0]    shift_q,  shift_d;
    logic [AW:0]   len_q,    len_d;
    logic          launch_q, launch_d;
    logic [AW-1:0] idx_q,    idx_d;
    logic          tx_q,     tx_d;
    logic          busy_q,   busy_d;
    logic          done_q,   done_d;
`ifdef UART_MSG_PARITY_EN
    logic          par_q,    par_d;
`endif

    logic          baud_end;
    logic          last_byte;
    logic [AW-1:0] idx_nxt;

    // Buffer contents are deliberately not reset.
    always_ff @(posedge RST_clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign baud_end  = (cnt_q == CNT_MAX);
    assign idx_nxt   = idx_q + AW'(1);
    assign last_byte = ((AW + 1)'(idx_q) + (AW + 1)'(1)) >= len_q;

    always_comb begin
        state_d  = state_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        len_d    = len_q;
        launch_d = 1'b0;
        idx_d    = idx_q;
        tx_d     = tx_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
`ifdef UART_MSG_PARITY_EN
        par_d    = par_q;
`endif
        cnt_d    = (state_q == S_IDLE || baud_end) ? '0 : cnt_q + CW'(1);

        case (state_q)
            S_IDLE: begin
                // Length is latched one cycle ahead of the start bit so the first byte is read on the launch edge.
                if (launch_q) begin
                    if (len_q == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_START;
                        tx_d    = 1'b0;
                        busy_d  = 1'b1;
                        idx_d   = '0;
                        shift_d = mem_q[0];
`ifdef UART_MSG_PARITY_EN
                        par_d   = ^mem_q[0];
`endif
                    end
                end else if (start) begin
                    len_d    = (msg_len > DEPTH_L) ? DEPTH_L : msg_len;
                    launch_d = 1'b1;
                end
            end
            S_START: begin
                if (baud_end) begin
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    if (bit_q == 3'd7) begin
`ifdef UART_MSG_PARITY_EN
                        state_d = S_PARITY;
                        tx_d    = par_q;
`else
                        state_d = S_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end
            end
`ifdef UART_MSG_PARITY_EN
            S_PARITY: begin
                if (baud_end) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (baud_end) begin
                    if (!last_byte) begin
                        state_d = S_START;
                        tx_d    = 1'b0;
                        idx_d   = idx_nxt;
                        shift_d = mem_q[idx_nxt];
`ifdef UART_MSG_PARITY_EN
                        par_d   = ^mem_q[idx_nxt];
`endif
                    end else begin
                        done_d = 1'b1;
                        if (repeat_en) begin
                            state_d = S_START;
                            tx_d    = 1'b0;
                            idx_d   = '0;
                            shift_d = mem_q[0];
`ifdef UART_MSG_PARITY_EN
                            par_d   = ^mem_q[0];
`endif
                        end else begin
                            state_d = S_IDLE;
                            busy_d  = 1'b0;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge RST_clk or negedge RST_n) begin
        if (!RST_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            len_q    <= '0;
            launch_q <= 1'b0;
            idx_q    <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef UART_MSG_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            len_q    <= len_d;
            launch_q <= launch_d;
            idx_q    <= idx_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef UART_MSG_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

    assign uart_tx_data = tx_q;
    assign uart_busy    = busy_q;
    assign done         = done_q;
    assign cur_idx      = idx_q;

endmodule

// File: tb/tb_uart_msg_tx.sv
// Bench for uart_msg_tx: directed steps, line decoder popping an expected-byte scoreboard.
module tb_uart_msg_tx;

    localparam int BD    = 4;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
`ifdef UART_MSG_PARITY_EN
    localparam int FB    = 11;
`else
    localparam int FB    = 10;
`endif
    localparam int FC    = FB * BD;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          wr_en     = 1'b0;
    logic [AW-1:0] wr_addr   = '0;
    logic [7:0]    wr_data   = '0;
    logic [AW:0]   msg_len   = '0;
    logic          start     = 1'b0;
    logic          repeat_en = 1'b0;
    logic          tx;
    logic          busy;
    logic          done;
    logic [AW-1:0] cur_idx;

    int            tests = 0;
    int            fails = 0;
    logic [7:0]    exp_q [$];
    bit            abort_flag = 1'b0;
    logic [7:0]    m_got;
    logic [7:0]    m_exp;
    logic          m_stop;
`ifdef UART_MSG_PARITY_EN
    logic          m_par;
`endif

    uart_msg_tx #(.BAUD_DIV(BD), .DEPTH(DEPTH), .AW(AW)) dut (
        .RST_clk      (clk),
        .RST_n        (rst_n),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .msg_len      (msg_len),
        .start        (start),
        .repeat_en    (repeat_en),
        .uart_tx_data (tx),
        .uart_busy    (busy),
        .done         (done),
        .cur_idx      (cur_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
`ifdef UART_MSG_PARITY_EN
        if (b == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    task automatic wr(input int a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    // Returns at the negedge following the edge that samples start.
    task automatic pulse_start(input int len);
        msg_len = (AW + 1)'(len);
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    always @(negedge rst_n) abort_flag = 1'b1;

    // Line decoder: samples mid-bit and pops the scoreboard per completed frame.
    initial forever begin
        @(negedge clk);
        if (rst_n === 1'b1 && tx === 1'b0) begin
            abort_flag = 1'b0;
            repeat (BD / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (BD) @(negedge clk);
                m_got[i] = tx;
            end
`ifdef UART_MSG_PARITY_EN
            repeat (BD) @(negedge clk);
            m_par = tx;
`endif
            repeat (BD) @(negedge clk);
            m_stop = tx;
            if (!abort_flag) begin
                tests++;
                assert (exp_q.size() > 0) else begin
                    fails++;
                    $error("FAIL frame_unexpected: observed %02h expected no frame", m_got);
                end
                if (exp_q.size() > 0) begin
                    m_exp = exp_q.pop_front();
                    check("frame_data", 32'(m_got), 32'(m_exp));
`ifdef UART_MSG_PARITY_EN
                    check("frame_parity", 32'(m_par), 32'(^m_exp));
`endif
                end
                check("frame_stop", 32'(m_stop), 32'd1);
            end
        end
    end

    initial begin
        int busy_cnt;
        int done_cnt;
        int first_done;
        string s;

        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_idx", 32'(cur_idx), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single frame, cycle-exact waveform.
        wr(0, 8'h63);
        exp_q.push_back(8'h63);
        pulse_start(1);
        check("t1_c0_busy", 32'(busy), 32'd0);
        check("t1_c0_tx", 32'(tx), 32'd1);
        for (int k = 1; k <= FC + 1; k++) begin
            @(negedge clk);
            if (k <= FC) begin
                check("t1_tx", 32'(tx), 32'(exp_bit(8'h63, (k - 1) / BD)));
                check("t1_busy", 32'(busy), 32'd1);
                check("t1_done", 32'(done), 32'd0);
            end else begin
                check("t1_done_end", 32'(done), 32'd1);
                check("t1_busy_end", 32'(busy), 32'd0);
                check("t1_tx_end", 32'(tx), 32'd1);
            end
        end
        @(negedge clk);
        check("t1_done_once", 32'(done), 32'd0);
        repeat (10) @(negedge clk);
        check("t1_drain", 32'(exp_q.size()), 32'd0);

        // Write to byte 0 on the edge that latches it: old value must go out.
        wr(0, 8'h3C);
        exp_q.push_back(8'h3C);
        msg_len = 1;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        wr_en   = 1'b1;
        wr_addr = '0;
        wr_data = 8'hC3;
        @(negedge clk);
        wr_en   = 1'b0;
        repeat (FC + 5) @(negedge clk);
        check("t2_drain", 32'(exp_q.size()), 32'd0);

        // Six back-to-back frames, with an ignored start mid-message.
        s = "cir";
        for (int i = 0; i < 6; i++) begin
            logic [7:0] b;
            b = (i < 3) ? s[i] : 8'hFF;
            wr(i, b);
            exp_q.push_back(b);
        end
        pulse_start(6);
        busy_cnt = 0;
        done_cnt = 0;
        for (int k = 1; k <= 6 * FC + 20; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (k <= 6 * FC && (k - 1) % FC == BD)
                check("t3_idx", 32'(cur_idx), 32'((k - 1) / FC));
            if (k == 100) begin
                msg_len = 1;
                start   = 1'b1;
            end
            if (k == 101) start = 1'b0;
        end
        check("t3_busy_cycles", 32'(busy_cnt), 32'(6 * FC));
        check("t3_done_count", 32'(done_cnt), 32'd1);
        check("t3_drain", 32'(exp_q.size()), 32'd0);

        // Zero length: done one cycle later, line untouched.
        pulse_start(0);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check("t4_done", 32'(done), (k == 1) ? 32'd1 : 32'd0);
            check("t4_busy", 32'(busy), 32'd0);
            check("t4_tx", 32'(tx), 32'd1);
        end

        // Repeat mode, dropped during the fourth pass.
        wr(0, 8'h55);
        wr(1, 8'hA5);
        for (int p = 0; p < 4; p++) begin
            exp_q.push_back(8'h55);
            exp_q.push_back(8'hA5);
        end
        repeat_en = 1'b1;
        pulse_start(2);
        busy_cnt = 0;
        done_cnt = 0;
        for (int k = 1; k <= 8 * FC + 10; k++) begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                check("t5_done_pos", 32'((k - 1) % (2 * FC)), 32'd0);
            end
            if (k <= 8 * FC && !busy) busy_cnt++;
            if (k == 8 * FC + 1) check("t5_busy_fall", 32'(busy), 32'd0);
            if (k == 6 * FC + FC / 2) repeat_en = 1'b0;
        end
        check("t5_done_count", 32'(done_cnt), 32'd4);
        check("t5_busy_gaps", 32'(busy_cnt), 32'd0);
        repeat (5) @(negedge clk);
        check("t5_drain", 32'(exp_q.size()), 32'd0);

        // Oversized length clamps to the full buffer.
        for (int i = 0; i < DEPTH; i++) begin
            wr(i, 8'(i) ^ 8'h5A);
            exp_q.push_back(8'(i) ^ 8'h5A);
        end
        pulse_start(40);
        busy_cnt = 0;
        done_cnt = 0;
        for (int k = 1; k <= DEPTH * FC + 50; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) done_cnt++;
        end
        check("t6_busy_cycles", 32'(busy_cnt), 32'(DEPTH * FC));
        check("t6_done_count", 32'(done_cnt), 32'd1);
        check("t6_drain", 32'(exp_q.size()), 32'd0);

        // Frame length for 0x07 (parity bit set in the parity build).
        wr(0, 8'h07);
        exp_q.push_back(8'h07);
        pulse_start(1);
        first_done = 0;
        for (int k = 1; k <= FC + 10; k++) begin
            @(negedge clk);
            if (done && first_done == 0) first_done = k;
        end
        check("t7_done_cycle", 32'(first_done), 32'(FC + 1));
        check("t7_drain", 32'(exp_q.size()), 32'd0);

        // Reset during data bit 3, then a clean resend.
        wr(0, 8'h96);
        exp_q.push_back(8'h96);
        pulse_start(1);
        repeat (1 + 4 * BD + 1) @(negedge clk);
        check("t8_pre_tx", 32'(tx), 32'd0);
        check("t8_pre_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t8_rst_tx", 32'(tx), 32'd1);
        check("t8_rst_busy", 32'(busy), 32'd0);
        check("t8_rst_idx", 32'(cur_idx), 32'd0);
        check("t8_rst_done", 32'(done), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (FC + 5) @(negedge clk);
        check("t8_idle_tx", 32'(tx), 32'd1);
        exp_q.push_back(8'h96);
        pulse_start(1);
        first_done = 0;
        for (int k = 1; k <= FC + 10; k++) begin
            @(negedge clk);
            if (done && first_done == 0) first_done = k;
        end
        check("t8_done_cycle", 32'(first_done), 32'(FC + 1));
        check("t8_drain", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_msg_tx.md
# uart_msg_tx

Parametrised UART message transmitter: holds a software-loadable byte buffer and serialises the first `msg_len` bytes as 8N1 UART frames on a single pin, once or in continuous repeat. Contains its own baud counter and serialiser. It is the next-generation display/terminal message sender: string content, length and repeat mode are runtime inputs instead of fixed constants.

## Interface

**Parameters**
- `BAUD_DIV`, default 5208: clock cycles per UART bit (50 MHz / 9600); legal range ≥ 2.
- `DEPTH`, default 32: buffer depth in bytes; power of two.
- `AW`, default 5: address width, equal to log2(DEPTH).

**Ports**
- `RST_clk`  in  1: system clock; all logic on the rising edge.
- `RST_n`  in  1: asynchronous, active-low reset.
- `wr_en`  in  1: buffer write strobe.
- `wr_addr`  in  AW: buffer write address.
- `wr_data`  in  8: buffer write data.
- `msg_len`  in  AW+1: number of bytes to send; sampled on an accepted `start`.
- `start`  in  1: single-cycle request to begin a message.
- `repeat_en`  in  1: when high at message end, the message restarts.
- `uart_tx_data`  out  1: serial line; idle high.
- `uart_busy`  out  1: high while a message is in progress.
- `done`  out  1: one-cycle pulse at the end of each message pass.
- `cur_idx`  out  AW: index of the byte currently on the line.

## Operation

- **Buffer:** DEPTH×8 register array; no reset of contents.
  - A write updates it on the clock edge, in any state.
  - A byte is latched into the shift register when its start bit begins. Writing a byte after it has been latched does not affect the frame in flight.
- **State machine:** IDLE, START, DATA, STOP.
- **IDLE → START:**
  - On `start=1` with latched length `len` in 1..DEPTH.
  - `msg_len > DEPTH` is clamped to DEPTH.
  - `start` with `msg_len=0` sends nothing; `done` pulses the next cycle and the block stays in IDLE.
- **START:** line low for BAUD_DIV cycles, then DATA.
- **DATA:** 8 bits, LSB first, BAUD_DIV cycles each, then STOP.
- **STOP:** line high for BAUD_DIV cycles. At the end of STOP:
  - If `cur_idx < len-1`: increment `cur_idx` and go to START with no gap.
  - Otherwise: pulse `done`. Then, if `repeat_en=1`, set `cur_idx=0` and go to START. Else go to IDLE.
- `start` is ignored while `uart_busy=1`.
- `repeat_en` is sampled only at the end of the final STOP bit. Clearing it mid-message lets the current pass complete.
- **Arithmetic:**
  - The baud counter counts 0..BAUD_DIV-1 and wraps.
  - The bit counter counts 0..7.
  - `cur_idx` wraps only through an explicit reset to 0, never by overflow.

## Timing

- **Reset values:** `uart_tx_data=1`, `uart_busy=0`, `done=0`, `cur_idx=0`; state IDLE; counters 0.
- **Reset mid-frame:** the line returns high asynchronously. The partial frame is abandoned and is not resumed.
- **Start latency:** with `start` high at edge N, `uart_tx_data` falls and `uart_busy` rises at edge N+1. All outputs are registered.
- **Frame length:** one frame is 10×BAUD_DIV cycles; byte k's start bit begins 10×BAUD_DIV×k cycles after the first.
- **End of message:** `done` is high for exactly the one cycle following the last stop-bit cycle.
  - Without repeat, `uart_busy` falls on that same cycle.
  - With repeat, `uart_busy` stays high and the next start bit begins on that same cycle.
- **Simultaneous events:** a write to the byte being latched on the same edge does not take effect for that frame; the old value is sent.

## Configuration

- **`UART_MSG_PARITY_EN` defined:**
  - A PARITY state is inserted between DATA and STOP, lasting BAUD_DIV cycles.
  - It carries even parity: the XOR of the 8 data bits.
  - A frame is then 11×BAUD_DIV cycles, and all frame-length timing above scales accordingly.
- **Not defined:** pure 8N1 with no parity state, 10×BAUD_DIV cycles per frame.

## Test plan

- **Single frame:** BAUD_DIV=4; write 0x63 at address 0; `msg_len=1`, pulse `start`.
  - Line shows 0,1,1,0,0,0,1,1,0,1, each bit 4 cycles.
  - `done` pulses at cycle 41; `uart_busy` is high for cycles 1–40.
- **Multi-byte message:** load "cir" plus 0xFF,0xFF,0xFF; `msg_len=6`.
  - Six back-to-back frames are decoded correctly.
  - `cur_idx` steps 0..5; one `done` pulse; total 240 busy cycles.
- **Repeat:** `msg_len=2`, `repeat_en=1`.
  - `done` pulses every 80 cycles with `uart_busy` continuously high.
  - After `repeat_en` is dropped mid-pass, that pass finishes and `uart_busy` then falls.
- **Boundaries:**
  - `start` with `msg_len=0`: no line activity, `done` one cycle later.
  - `msg_len=40` with DEPTH=32: exactly 32 frames.
  - `start` while busy: ignored.
- **Reset mid-frame:** assert `RST_n=0` during DATA bit 3.
  - Line is high immediately; `uart_busy=0`, `cur_idx=0`.
  - A new `start` after release sends byte 0 correctly.
- **Parity build:** with `UART_MSG_PARITY_EN` defined, send 0x07.
  - Parity bit is 1; frame is 44 cycles at BAUD_DIV=4.
